des_key_sched_ctrl: RTL and testbench



---
 rtl/des_key_pkg.sv | 71 +++++++
 rtl/des_cd_rotate.sv | 49 ++++
 rtl/des_key_sched_ctrl.sv | 149 ++++++++++++++
 tb/tb_des_key_sched_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_key_pkg.sv
// Shared DES key-schedule definitions: permutation tables, per-step
// rotation amounts, permutation helpers and the scheduler state type.
package des_key_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // PC-1 in DES numbering (bit 1 = key MSB); output bit 1 first.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2 in DES numbering over the 56-bit C||D (bit 1 = C MSB).
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left rotations applied before each encrypt round key.
    localparam logic [1:0] ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Right rotations for decrypt; the leading 0 works because the
    // encrypt rotations sum to 28, so CD16 equals CD0.
    localparam logic [1:0] DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Permuted choice 1: 64-bit key to 56-bit C||D, parity bits dropped.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  pos;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            pos = 6'(64 - PC1_TAB[i[5:0]]);
            r   = {r[54:0], k[pos]};
        end
        return r;
    endfunction

    // Permuted choice 2: 56-bit C||D to 48-bit round key.
    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  pos;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            pos = 6'(56 - PC2_TAB[i[5:0]]);
            r   = {r[46:0], cd[pos]};
        end
        return r;
    endfunction

endpackage

// File: rtl/des_cd_rotate.sv
// Combinational 28-bit circular rotation of the C and D key halves.
// dir=0 rotates left (encrypt), dir=1 rotates right (decrypt).
module des_cd_rotate (
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic [1:0]  amt,
    input  logic        dir,
    output logic [27:0] c_rot,
    output logic [27:0] d_rot
);

    function automatic logic [27:0] rot28(input logic [27:0] x,
                                          input logic [1:0]  n,
                                          input logic        right);
        logic [27:0] r;
        if (!right) begin
            case (n)
                2'd1:    r = {x[26:0], x[27]};
                2'd2:    r = {x[25:0], x[27:26]};
                2'd3:    r = {x[24:0], x[27:25]};
                default: r = x;
            endcase
        end else begin
            case (n)
                2'd1:    r = {x[0],   x[27:1]};
                2'd2:    r = {x[1:0], x[27:2]};
                2'd3:    r = {x[2:0], x[27:3]};
                default: r = x;
            endcase
        end
        return r;
    endfunction

    logic [1:0][27:0] half_in;
    logic [1:0][27:0] half_out;

    assign half_in = {c, d};

    // Each half rotates independently; nothing carries between C and D.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            assign half_out[gi] = rot28(half_in[gi], amt, dir);
        end
    endgenerate

    assign c_rot = half_out[1];
    assign d_rot = half_out[0];

endmodule

// File: rtl/des_key_sched_ctrl.sv
// Sequential DES round-key scheduler: PC-1 once at start, then one C/D
// rotation and PC-2 per emitted key, in encrypt or decrypt order, with
// a valid/ready handshake towards the round datapath.
import des_key_pkg::*;

module des_key_sched_ctrl #(
    parameter int NROUNDS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        abort,
    output logic [47:0] rkey,
    output logic        rkey_valid,
    input  logic        rkey_ready,
    output logic [3:0]  round_idx,
    output logic        rkey_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] NR_STEPS  = 5'(NROUNDS);
    localparam logic [4:0] LAST_STEP = 5'(NROUNDS - 1);

    state_t      state_reg, state_next;
    logic [27:0] c_reg, c_next;
    logic [27:0] d_reg, d_next;
    logic        mode_reg, mode_next;
    logic [4:0]  step_reg, step_next;
    logic [47:0] rkey_reg, rkey_next;
    logic        valid_reg, valid_next;
    logic [3:0]  idx_reg, idx_next;
    logic        last_reg, last_next;
    logic        done_reg, done_next;

    logic [1:0]  amt;
    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic        accept_last;
    logic        can_produce;

    assign amt = mode_reg ? DEC_SHIFT[step_reg[3:0]] : ENC_SHIFT[step_reg[3:0]];

    des_cd_rotate u_rotate (
        .c     (c_reg),
        .d     (d_reg),
        .amt   (amt),
        .dir   (mode_reg),
        .c_rot (c_rot),
        .d_rot (d_rot)
    );

    // A new key may be produced when the output slot is empty or being
    // drained this cycle, and keys remain to be produced.
    assign accept_last = valid_reg & rkey_ready & last_reg;
    assign can_produce = (!valid_reg || rkey_ready) && (step_reg < NR_STEPS);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and datapath next values; abort overrides everything.
    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        d_next     = d_reg;
        mode_next  = mode_reg;
        step_next  = step_reg;
        rkey_next  = rkey_reg;
        valid_next = valid_reg;
        idx_next   = idx_reg;
        last_next  = last_reg;
        done_next  = 1'b0;

        if (abort) begin
            state_next = IDLE;
            valid_next = 1'b0;
            last_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next       = RUN;
                        {c_next, d_next} = pc1(key);
                        mode_next        = decrypt;
                        step_next        = '0;
                    end
                end
                RUN: begin
                    if (accept_last) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        done_next  = 1'b1;
                    end else if (can_produce) begin
                        c_next     = c_rot;
                        d_next     = d_rot;
                        rkey_next  = pc2({c_rot, d_rot});
                        valid_next = 1'b1;
                        idx_next   = mode_reg ? 4'(LAST_STEP - step_reg) : step_reg[3:0];
                        last_next  = (step_reg == LAST_STEP);
                        step_next  = step_reg + 5'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            c_reg     <= '0;
            d_reg     <= '0;
            mode_reg  <= 1'b0;
            step_reg  <= '0;
            rkey_reg  <= '0;
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            c_reg     <= c_next;
            d_reg     <= d_next;
            mode_reg  <= mode_next;
            step_reg  <= step_next;
            rkey_reg  <= rkey_next;
            valid_reg <= valid_next;
            idx_reg   <= idx_next;
            last_reg  <= last_next;
            done_reg  <= done_next;
        end
    end

    assign rkey       = rkey_reg;
    assign rkey_valid = valid_reg;
    assign round_idx  = idx_reg;
    assign rkey_last  = last_reg;
    assign done       = done_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench for des_key_sched_ctrl: a reference key schedule
// fills the expected queue at start; the monitor compares every valid
// cycle against the queue head and pops on each handshake.
module tb_des_key_sched_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic        abort;
    logic [47:0] rkey;
    logic        rkey_valid;
    logic        rkey_ready;
    logic [3:0]  round_idx;
    logic        rkey_last;
    logic        busy;
    logic        done;

    des_key_sched_ctrl #(.NROUNDS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .key        (key),
        .decrypt    (decrypt),
        .abort      (abort),
        .rkey       (rkey),
        .rkey_valid (rkey_valid),
        .rkey_ready (rkey_ready),
        .round_idx  (round_idx),
        .rkey_last  (rkey_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_P = 64'h123457799ABCDEF0;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic [47:0] rk;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb_q [$];
    logic [47:0] acc_q [$];
    logic [47:0] enc_seq [16];
    exp_t        mon_e;

    int  total = 0;
    int  bad = 0;
    int  hs_cnt = 0;
    int  done_cnt = 0;
    time done_time = 0;
    time t_start = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference schedule: key n is PC2 of CD0 rotated left by the
    // cumulative shift count up to and including round n.
    function automatic logic [47:0] model_key(input logic [63:0] k, input int rnd);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] r;
        int          total_sh;
        cd = '0;
        for (int i = 0; i < 56; i++)
            cd = {cd[54:0], k[6'(64 - M_PC1[i[5:0]])]};
        c = cd[55:28];
        d = cd[27:0];
        total_sh = 0;
        for (int j = 0; j <= rnd; j++)
            total_sh += M_SH[j[3:0]];
        for (int s = 0; s < total_sh % 28; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        r = '0;
        for (int i = 0; i < 48; i++)
            r = {r[46:0], cd[6'(56 - M_PC2[i[5:0]])]};
        return r;
    endfunction

    task automatic tick(input bit rnd);
        @(posedge CLK);
        #1;
        rkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Monitor: one line per accepted key.
    always @(negedge CLK) begin
        if (done) begin
            done_cnt++;
            done_time = $time;
        end
        if (rkey_valid) begin
            if (sb_q.size() == 0) begin
                check("valid_unexpected", 64'(rkey_valid), 64'd0);
            end else begin
                mon_e = sb_q[0];
                check("rkey", 64'(rkey), 64'(mon_e.rk));
                check("round_idx", 64'(round_idx), 64'(mon_e.idx));
                check("rkey_last", 64'(rkey_last), 64'(mon_e.last));
                if (rkey_ready) begin
                    void'(sb_q.pop_front());
                    acc_q.push_back(rkey);
                    hs_cnt++;
                    $display("hs %0d idx=%0d rkey=%h last=%0b", hs_cnt, round_idx, rkey, rkey_last);
                end
            end
        end
    end

    // One schedule. inj_kind: 0 none, 1 start while busy, 2 abort, 3 reset;
    // the injection fires once inj_at keys have been accepted.
    task automatic run(input logic [63:0] k, input bit dec, input bit rnd,
                       input int inj_at, input int inj_kind);
        int  d0;
        bit  fin;
        bit  injd;
        tick(rnd);
        for (int i = 0; i < 16; i++) begin
            int r;
            r = dec ? 15 - i : i;
            sb_q.push_back('{rk: model_key(k, r), idx: 4'(r), last: (i == 15)});
        end
        acc_q.delete();
        hs_cnt = 0;
        d0 = done_cnt;
        key = k;
        decrypt = dec;
        start = 1'b1;
        t_start = $time + 4;
        tick(rnd);
        start = 1'b0;
        key = ~k;
        decrypt = ~dec;
        @(negedge CLK);
        check("lat_t1_valid", 64'(rkey_valid), 64'd0);
        check("lat_t1_busy", 64'(busy), 64'd1);
        tick(rnd);
        @(negedge CLK);
        check("lat_t2_valid", 64'(rkey_valid), 64'd1);
        fin = 1'b0;
        injd = 1'b0;
        for (int n = 0; n < 400 && !fin; n++) begin
            tick(rnd);
            start = 1'b0;
            if (!injd && inj_kind != 0 && hs_cnt == inj_at) begin
                injd = 1'b1;
                if (inj_kind == 1) begin
                    start = 1'b1;
                    key = KEY_B;
                    decrypt = ~dec;
                end else begin
                    rkey_ready = 1'b0;
                    if (inj_kind == 2) abort = 1'b1;
                    else RST = 1'b1;
                    @(posedge CLK);
                    #1;
                    abort = 1'b0;
                    RST = 1'b0;
                    @(negedge CLK);
                    check("cut_valid", 64'(rkey_valid), 64'd0);
                    check("cut_busy", 64'(busy), 64'd0);
                    check("cut_last", 64'(rkey_last), 64'd0);
                    if (inj_kind == 3) begin
                        check("rst_rkey", 64'(rkey), 64'd0);
                        check("rst_idx", 64'(round_idx), 64'd0);
                        check("rst_done", 64'(done), 64'd0);
                    end
                    sb_q.delete();
                    repeat (4) tick(1'b0);
                    check("cut_no_done", 64'(done_cnt - d0), 64'd0);
                    check("cut_idle_valid", 64'(rkey_valid), 64'd0);
                    return;
                end
            end
            if (done_cnt != d0) fin = 1'b1;
        end
        start = 1'b0;
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("handshakes", 64'(hs_cnt), 64'd16);
        check("sb_left", 64'(sb_q.size()), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("valid_after", 64'(rkey_valid), 64'd0);
        if (!rnd) check("done_cycle", 64'(done_time), 64'(t_start + 180));
    endtask

    initial begin
        RST = 1'b1;
        start = 1'b0;
        key = '0;
        decrypt = 1'b0;
        abort = 1'b0;
        rkey_ready = 1'b1;
        repeat (3) tick(1'b0);
        @(negedge CLK);
        check("rst_rkey", 64'(rkey), 64'd0);
        check("rst_valid", 64'(rkey_valid), 64'd0);
        check("rst_idx", 64'(round_idx), 64'd0);
        check("rst_last", 64'(rkey_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        RST = 1'b0;

        // Encrypt, ready held high, with known-answer keys.
        run(KEY_A, 1'b0, 1'b0, -1, 0);
        check("kat_k1", 64'(acc_q[0]), 64'h1B02EFFC7072);
        check("kat_k2", 64'(acc_q[1]), 64'h79AED9DBC9E5);
        check("kat_k16", 64'(acc_q[15]), 64'hCB3D8B0E17F5);
        for (int i = 0; i < 16; i++) enc_seq[i] = acc_q[i];

        // Decrypt must be the exact reverse.
        run(KEY_A, 1'b1, 1'b0, -1, 0);
        check("dec_first", 64'(acc_q[0]), 64'hCB3D8B0E17F5);
        check("dec_last", 64'(acc_q[15]), 64'h1B02EFFC7072);
        for (int i = 0; i < 16; i++) check("dec_reverse", 64'(acc_q[i]), 64'(enc_seq[15 - i]));

        // Random backpressure.
        run(KEY_A, 1'b0, 1'b1, -1, 0);
        for (int i = 0; i < 16; i++) check("bp_seq", 64'(acc_q[i]), 64'(enc_seq[i]));

        // Parity bits ignored.
        run(KEY_P, 1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 16; i++) check("parity_seq", 64'(acc_q[i]), 64'(enc_seq[i]));

        // start while busy is ignored.
        run(KEY_A, 1'b0, 1'b0, 5, 1);
        for (int i = 0; i < 16; i++) check("busy_start_seq", 64'(acc_q[i]), 64'(enc_seq[i]));

        // abort after the 7th key, then a full decrypt schedule.
        run(KEY_A, 1'b0, 1'b0, 7, 2);
        run(KEY_A, 1'b1, 1'b0, -1, 0);
        for (int i = 0; i < 16; i++) check("post_abort_seq", 64'(acc_q[i]), 64'(enc_seq[15 - i]));

        // reset after the 7th key, then a full encrypt schedule.
        run(KEY_A, 1'b0, 1'b0, 7, 3);
        run(KEY_A, 1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 16; i++) check("post_rst_seq", 64'(acc_q[i]), 64'(enc_seq[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
